// File: rtl/pipeline_stall_ctrl.sv
// Central hazard controller: merges per-stage stall requests, sequences held flush pulses
// with a redirect PC, and counts stalled fetch cycles.
module pipeline_stall_ctrl #(
    parameter int STAGES     = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int FLUSH_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAGES-1:0]     stall_req,
    input  logic                  flush_req,
    input  logic [ADDR_WIDTH-1:0] flush_target,
    output logic [STAGES-1:0]     stall,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  busy_flushing,
    output logic [31:0]           stall_cycles
);

    localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(FLUSH_HOLD - 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01
    } state_t;

    state_t                state, state_nxt;
    logic [HW-1:0]         hold, hold_nxt;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [31:0]           cnt_nxt;

    assign flush         = (state == FLUSH);
    assign busy_flushing = flush;

    // A stall at stage j backs up every earlier stage; flush and reset override everything.
    for (genvar i = 0; i < STAGES; i++) begin : g_merge
        assign stall[i] = (|stall_req[STAGES-1:i]) & ~flush & ~rst;
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        pc_nxt    = flush_pc;
        case (state)
            RUN: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                    hold_nxt  = HOLD_INIT;
                    pc_nxt    = flush_target;
                end
            end
            FLUSH: begin
                // A new redirect while flushing restarts the hold window with the newer PC.
                if (flush_req) begin
                    hold_nxt = HOLD_INIT;
                    pc_nxt   = flush_target;
                end else if (hold == '0) begin
                    state_nxt = RUN;
                end else begin
                    hold_nxt = hold - 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                hold_nxt  = '0;
            end
        endcase
    end

    // stall[0] is already masked by flush and reset, so it alone gates the count.
    assign cnt_nxt = (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) ? stall_cycles + 32'd1
                                                                   : stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            hold         <= '0;
            flush_pc     <= '0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nxt;
            hold         <= hold_nxt;
            flush_pc     <= pc_nxt;
            stall_cycles <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl (STAGES=5, FLUSH_HOLD=2).
module tb_pipeline_stall_ctrl;

    localparam int STAGES = 5;
    localparam int AW     = 32;

    logic              clk;
    logic              rst;
    logic [STAGES-1:0] stall_req;
    logic              flush_req;
    logic [AW-1:0]     flush_target;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [AW-1:0]     flush_pc;
    logic              busy_flushing;
    logic [31:0]       stall_cycles;

    pipeline_stall_ctrl #(.STAGES(STAGES), .ADDR_WIDTH(AW), .FLUSH_HOLD(2)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
        .flush_target(flush_target), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .busy_flushing(busy_flushing), .stall_cycles(stall_cycles)
    );

    // mask bits: 0 stall, 1 flush+busy, 2 flush_pc, 3 stall_cycles
    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [4:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: drive inputs at the falling edge and queue what the DUT must show this cycle.
    // act: 1 = preload the counter via force, 2 = release it.
    task automatic cyc(input string nm, input int act, input logic r, input logic [4:0] sr,
                       input logic fr, input logic [31:0] tg, input logic [3:0] m,
                       input logic [4:0] es, input logic ef, input logic [31:0] ep,
                       input logic [31:0] ec);
        exp_t e;
        @(negedge clk);
        if (act == 1) force dut.stall_cycles = 32'hFFFF_FFFE;
        if (act == 2) release dut.stall_cycles;
        rst          = r;
        stall_req    = sr;
        flush_req    = fr;
        flush_target = tg;
        e.name  = nm;
        e.mask  = m;
        e.stall = es;
        e.flush = ef;
        e.pc    = ep;
        e.cnt   = ec;
        q.push_back(e);
    endtask

    // Monitor: samples just before each rising edge, once per queued cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[0]) begin
                    vectors++;
                    if (stall !== e.stall) begin
                        miscompares++;
                        $display("FAIL %s.stall got %b want %b", e.name, stall, e.stall);
                    end
                end
                if (e.mask[1]) begin
                    vectors++;
                    if (flush !== e.flush || busy_flushing !== e.flush) begin
                        miscompares++;
                        $display("FAIL %s.flush got %b/%b want %b", e.name, flush,
                                 busy_flushing, e.flush);
                    end
                end
                if (e.mask[2]) begin
                    vectors++;
                    if (flush_pc !== e.pc) begin
                        miscompares++;
                        $display("FAIL %s.flush_pc got %h want %h", e.name, flush_pc, e.pc);
                    end
                end
                if (e.mask[3]) begin
                    vectors++;
                    if (stall_cycles !== e.cnt) begin
                        miscompares++;
                        $display("FAIL %s.stall_cycles got %h want %h", e.name, stall_cycles,
                                 e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall_req = '1; flush_req = 1'b0; flush_target = '0;
        //  name        act rst req       fr  target        mask     stall     fl  pc            cnt
        // reset
        cyc("t1_c0",    0, 1, 5'b11111, 0, 32'h0,         4'b0001, 5'b00000, 0, 32'h0,        32'd0);
        cyc("t1_c1",    0, 1, 5'b11111, 0, 32'h0,         4'b1111, 5'b00000, 0, 32'h0,        32'd0);
        // stall merge
        cyc("t2_a",     0, 0, 5'b00100, 0, 32'h0,         4'b1011, 5'b00111, 0, 32'h0,        32'd0);
        cyc("t2_b",     0, 0, 5'b00100, 0, 32'h0,         4'b1011, 5'b00111, 0, 32'h0,        32'd1);
        cyc("t2_c",     0, 0, 5'b00100, 0, 32'h0,         4'b1011, 5'b00111, 0, 32'h0,        32'd2);
        cyc("t2_d",     0, 0, 5'b00000, 0, 32'h0,         4'b1011, 5'b00000, 0, 32'h0,        32'd3);
        cyc("t2_e",     0, 0, 5'b00001, 0, 32'h0,         4'b1011, 5'b00001, 0, 32'h0,        32'd3);
        cyc("t2_f",     0, 0, 5'b01000, 0, 32'h0,         4'b1011, 5'b01111, 0, 32'h0,        32'd4);
        cyc("t2_g",     0, 0, 5'b00000, 0, 32'h0,         4'b1011, 5'b00000, 0, 32'h0,        32'd5);
        // flush hold of two cycles
        cyc("t3_t",     0, 0, 5'b00000, 1, 32'h8000_0180, 4'b1011, 5'b00000, 0, 32'h0,        32'd5);
        cyc("t3_t1",    0, 0, 5'b00000, 0, 32'h0,         4'b1111, 5'b00000, 1, 32'h8000_0180, 32'd5);
        cyc("t3_t2",    0, 0, 5'b00000, 0, 32'h0,         4'b0110, 5'b00000, 1, 32'h8000_0180, 32'd5);
        cyc("t3_t3",    0, 0, 5'b00000, 0, 32'h0,         4'b1010, 5'b00000, 0, 32'h0,        32'd5);
        // flush over stall
        cyc("t4_t",     0, 0, 5'b10000, 1, 32'h0000_0040, 4'b1011, 5'b11111, 0, 32'h0,        32'd5);
        cyc("t4_t1",    0, 0, 5'b10000, 0, 32'h0,         4'b1111, 5'b00000, 1, 32'h0000_0040, 32'd6);
        cyc("t4_t2",    0, 0, 5'b10000, 0, 32'h0,         4'b1011, 5'b00000, 1, 32'h0,        32'd6);
        cyc("t4_t3",    0, 0, 5'b10000, 0, 32'h0,         4'b1011, 5'b11111, 0, 32'h0,        32'd6);
        cyc("t4_t4",    0, 0, 5'b00000, 0, 32'h0,         4'b1011, 5'b00000, 0, 32'h0,        32'd7);
        // back-to-back redirects
        cyc("t5_t",     0, 0, 5'b00000, 1, 32'h0000_0100, 4'b0010, 5'b00000, 0, 32'h0,        32'd7);
        cyc("t5_t1",    0, 0, 5'b00000, 1, 32'h0000_0200, 4'b0110, 5'b00000, 1, 32'h0000_0100, 32'd7);
        cyc("t5_t2",    0, 0, 5'b00011, 0, 32'h0,         4'b1111, 5'b00000, 1, 32'h0000_0200, 32'd7);
        cyc("t5_t3",    0, 0, 5'b00000, 0, 32'h0,         4'b0110, 5'b00000, 1, 32'h0000_0200, 32'd7);
        cyc("t5_t4",    0, 0, 5'b00000, 0, 32'h0,         4'b1010, 5'b00000, 0, 32'h0,        32'd7);
        // saturation
        cyc("t6_pre",   1, 0, 5'b00000, 0, 32'h0,         4'b1000, 5'b00000, 0, 32'h0,        32'hFFFF_FFFE);
        cyc("t6_a",     2, 0, 5'b00001, 0, 32'h0,         4'b1001, 5'b00001, 0, 32'h0,        32'hFFFF_FFFE);
        cyc("t6_b",     0, 0, 5'b00001, 0, 32'h0,         4'b1000, 5'b00001, 0, 32'h0,        32'hFFFF_FFFF);
        cyc("t6_c",     0, 0, 5'b00001, 0, 32'h0,         4'b1000, 5'b00001, 0, 32'h0,        32'hFFFF_FFFF);
        cyc("t6_d",     0, 0, 5'b00000, 0, 32'h0,         4'b1000, 5'b00000, 0, 32'h0,        32'hFFFF_FFFF);
        // reset mid-flush
        cyc("t6_fr",    0, 0, 5'b00000, 1, 32'h0000_0300, 4'b0010, 5'b00000, 0, 32'h0,        32'hFFFF_FFFF);
        cyc("t6_rst",   0, 1, 5'b11111, 0, 32'h0,         4'b0111, 5'b00000, 1, 32'h0000_0300, 32'hFFFF_FFFF);
        cyc("t6_post",  0, 0, 5'b00000, 0, 32'h0,         4'b1111, 5'b00000, 0, 32'h0,        32'd0);
        cyc("t6_run",   0, 0, 5'b00010, 0, 32'h0,         4'b1011, 5'b00011, 0, 32'h0,        32'd0);
        cyc("t6_end",   0, 0, 5'b00000, 0, 32'h0,         4'b1011, 5'b00000, 0, 32'h0,        32'd1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #6;
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
